// File: rtl/exec_pkg.sv
// exec_pkg: shared types and defaults for the execute stage
package exec_pkg;
  localparam int DATA_W = 16;
  localparam int REG_W = 3;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [2:0] {ADD, SUB, SHL, SHR, SRA, AND, OR, XOR} alu_op_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0] flags;
    logic [REG_W-1:0] dest_reg;
    logic set_flags;
  } exec_entry_t;
endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: upstream/downstream handshake bundle; Fwd* present only with EXEC_FWD_EN
interface alu_exec_stage_if import exec_pkg::*; #(parameter int DATA_W = 16, parameter int REG_W = 3);
  logic InValid;
  logic InReady;
  alu_op_t InOperation;
  logic [DATA_W-1:0] InOperand1;
  logic [DATA_W-1:0] InOperand2;
  logic [REG_W-1:0] InDestReg;
  logic InSetFlags;
  logic OutValid;
  logic OutReady;
  logic [DATA_W-1:0] OutResult;
  logic [3:0] OutFlags;
  logic [REG_W-1:0] OutDestReg;
  logic [3:0] FlagsReg;
`ifdef EXEC_FWD_EN
  logic FwdValid;
  logic [REG_W-1:0] FwdDestReg;
  logic [DATA_W-1:0] FwdResult;
`endif
  modport master(
    output InValid, InOperation, InOperand1, InOperand2, InDestReg, InSetFlags, OutReady,
    input InReady, OutValid, OutResult, OutFlags, OutDestReg, FlagsReg
`ifdef EXEC_FWD_EN
    , FwdValid, FwdDestReg, FwdResult
`endif
  );
  modport slave(
    input InValid, InOperation, InOperand1, InOperand2, InDestReg, InSetFlags, OutReady,
    output InReady, OutValid, OutResult, OutFlags, OutDestReg, FlagsReg
`ifdef EXEC_FWD_EN
    , FwdValid, FwdDestReg, FwdResult
`endif
  );
endinterface

// File: rtl/alu.sv
// alu: 16-bit combinational alu; C is carry-out on ADD and borrow on SUB, C/V are 0 for other ops
module alu import exec_pkg::*; (
  input alu_op_t op,
  input logic [15:0] a,
  input logic [15:0] b,
  output logic [15:0] result,
  output logic [3:0] flags
);
  logic [16:0] sum;
  logic [16:0] diff;
  logic c;
  logic v;
  always_comb begin
    sum = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    c = 1'b0;
    v = 1'b0;
    result = '0;
    case (op)
      ADD: begin
        result = sum[15:0];
        c = sum[16];
        v = (a[15] == b[15]) & (sum[15] != a[15]);
      end
      SUB: begin
        result = diff[15:0];
        c = diff[16];
        v = (a[15] != b[15]) & (diff[15] != a[15]);
      end
      SHL: result = a << b[3:0];
      SHR: result = a >> b[3:0];
      SRA: result = $signed(a) >>> b[3:0];
      AND: result = a & b;
      OR: result = a | b;
      XOR: result = a ^ b;
      default: result = '0;
    endcase
    flags = '0;
    flags[FLAG_C] = c;
    flags[FLAG_V] = v;
    flags[FLAG_N] = result[15];
    flags[FLAG_Z] = result == '0;
  end
endmodule

// File: rtl/exec_skid.sv
// exec_skid: 2-entry skid buffer (main feeds output, skid catches one op while output stalls); skid_data only with EXEC_FWD_EN
module exec_skid import exec_pkg::*; #(parameter type T = exec_entry_t) (
  input logic clk,
  input logic rst_n,
  input logic in_valid,
  input T in_data,
  input logic out_ready,
  output logic out_valid,
  output T out_data,
  output logic skid_valid
`ifdef EXEC_FWD_EN
  , output T skid_data
`endif
);
  logic main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic accept, retire, take;
  T main_q, main_d, skid_q, skid_d;
  always_comb begin
    accept = in_valid & ~skid_v_q;
    retire = main_v_q & out_ready;
    take = ~main_v_q | retire;
    main_v_d = take ? (skid_v_q | accept) : 1'b1;
    main_d = (take & skid_v_q) ? skid_q : (take & accept) ? in_data : main_q;
    skid_v_d = skid_v_q ? ~retire : (accept & ~take);
    skid_d = (accept & ~take) ? in_data : skid_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign out_valid = main_v_q;
  assign out_data = main_q;
  assign skid_valid = skid_v_q;
`ifdef EXEC_FWD_EN
  assign skid_data = skid_q;
`endif
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage (alu + skid buffer + flags register); EXEC_FWD_EN adds Fwd* bypass outputs
module alu_exec_stage import exec_pkg::*; #(
  parameter int DATA_W = exec_pkg::DATA_W,
  parameter int REG_W = exec_pkg::REG_W
) (
  input logic Clock,
  input logic ResetN,
  alu_exec_stage_if.slave bus
);
  if (DATA_W != 16) begin : g_bad_width
    $fatal(1, "alu_exec_stage: DATA_W must be 16");
  end
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [3:0] flags;
    logic [REG_W-1:0] dest_reg;
    logic set_flags;
  } entry_t;
  logic [DATA_W-1:0] alu_result;
  logic [3:0] alu_flags;
  logic main_v, skid_v;
  logic [3:0] flags_q, flags_d;
  entry_t in_e, main_e;
  alu u_alu (
    .op(bus.InOperation),
    .a(bus.InOperand1),
    .b(bus.InOperand2),
    .result(alu_result),
    .flags(alu_flags)
  );
  assign in_e = '{result: alu_result, flags: alu_flags, dest_reg: bus.InDestReg, set_flags: bus.InSetFlags};
`ifdef EXEC_FWD_EN
  entry_t skid_e;
`endif
  exec_skid #(.T(entry_t)) u_skid (
    .clk(Clock),
    .rst_n(ResetN),
    .in_valid(bus.InValid),
    .in_data(in_e),
    .out_ready(bus.OutReady),
    .out_valid(main_v),
    .out_data(main_e),
    .skid_valid(skid_v)
`ifdef EXEC_FWD_EN
    , .skid_data(skid_e)
`endif
  );
  assign bus.InReady = ~skid_v;
  assign bus.OutValid = main_v;
  assign bus.OutResult = main_e.result;
  assign bus.OutFlags = main_e.flags;
  assign bus.OutDestReg = main_e.dest_reg;
  always_comb flags_d = (main_v & bus.OutReady & main_e.set_flags) ? main_e.flags : flags_q;
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) flags_q <= '0;
    else flags_q <= flags_d;
  end
  assign bus.FlagsReg = flags_q;
`ifdef EXEC_FWD_EN
  // a younger write to the same register sits in skid, so main's value is already stale
  assign bus.FwdValid = main_v & ~(skid_v & (skid_e.dest_reg == main_e.dest_reg));
  assign bus.FwdDestReg = main_e.dest_reg;
  assign bus.FwdResult = main_e.result;
`endif
endmodule
